// File: rtl/serial_add_sub_if.sv
// Start/busy/done handshake and operand/result bundle for the digit-serial adder/subtractor.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output start, sub, a, b, carryIn,
    input  busy, done, sum, carry, overflow
  );

  modport slave (
    input  start, sub, a, b, carryIn,
    output busy, done, sum, carry, overflow
  );
endinterface

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, carry held in a register
// between slices; result, carry and signed overflow are published on the done pulse.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic             clk,
  input logic             reset,
  serial_add_sub_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_add_sub: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, res_q, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             c_q, busy_q, done_q, carry_q, ovf_q;

  logic [DIGIT:0]   slice_d;
  logic [WIDTH-1:0] res_d, opa_d, opb_d;
  logic             msb_cin_d;
  logic             last_d;

  always_comb begin
    slice_d   = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
    // Carry into the slice MSB falls out of its sum bit and the two operand bits.
    msb_cin_d = slice_d[DIGIT-1] ^ opa_q[DIGIT-1] ^ opb_q[DIGIT-1];
    res_d     = (res_q >> DIGIT) | (WIDTH'(slice_d[DIGIT-1:0]) << (WIDTH - DIGIT));
    opa_d     = opa_q >> DIGIT;
    opb_d     = opb_q >> DIGIT;
    last_d    = (cnt_q == CNT_W'(STEPS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // Subtraction runs as a + ~b + ~borrowIn, so carry-out means "no borrow".
            opa_q   <= bus.a;
            opb_q   <= bus.sub ? ~bus.b : bus.b;
            c_q     <= bus.sub ^ bus.carryIn;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          opa_q <= opa_d;
          opb_q <= opb_d;
          res_q <= res_d;
          c_q   <= slice_d[DIGIT];
          cnt_q <= cnt_q + 1'b1;
          if (last_d) begin
            sum_q   <= res_d;
            carry_q <= slice_d[DIGIT];
            ovf_q   <= msb_cin_d ^ slice_d[DIGIT];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: three 8-bit instances (DIGIT 1, 4, 8) driven by directed and random
// operations, checked against an integer-arithmetic model of add/subtract with flags.
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] start_r;
  logic [7:0] a_r, b_r;
  logic       cin_r, sub_r;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] prev_sum [3];
  logic       busy_w [3];
  logic       done_w [3];
  logic       carry_w [3];
  logic       ovf_w [3];
  logic [7:0] sum_w [3];

  serial_add_sub_if #(.WIDTH(8)) bus0 ();
  serial_add_sub_if #(.WIDTH(8)) bus1 ();
  serial_add_sub_if #(.WIDTH(8)) bus2 ();

  assign bus0.start = start_r[0];
  assign bus1.start = start_r[1];
  assign bus2.start = start_r[2];
  assign bus0.a = a_r;  assign bus1.a = a_r;  assign bus2.a = a_r;
  assign bus0.b = b_r;  assign bus1.b = b_r;  assign bus2.b = b_r;
  assign bus0.sub = sub_r;  assign bus1.sub = sub_r;  assign bus2.sub = sub_r;
  assign bus0.carryIn = cin_r;  assign bus1.carryIn = cin_r;  assign bus2.carryIn = cin_r;

  assign busy_w[0] = bus0.busy;  assign busy_w[1] = bus1.busy;  assign busy_w[2] = bus2.busy;
  assign done_w[0] = bus0.done;  assign done_w[1] = bus1.done;  assign done_w[2] = bus2.done;
  assign sum_w[0] = bus0.sum;    assign sum_w[1] = bus1.sum;    assign sum_w[2] = bus2.sum;
  assign carry_w[0] = bus0.carry;  assign carry_w[1] = bus1.carry;  assign carry_w[2] = bus2.carry;
  assign ovf_w[0] = bus0.overflow; assign ovf_w[1] = bus1.overflow; assign ovf_w[2] = bus2.overflow;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .reset(reset), .bus(bus0));
  serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .reset(reset), .bus(bus1));
  serial_add_sub #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .reset(reset), .bus(bus2));

  function automatic int steps_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 2 : 1;
  endfunction

  // Reference: returns {overflow, carry, sum[7:0]} from plain signed/unsigned integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] a, b, input logic cin, sub);
    int u, s;
    logic c, o;
    if (!sub) begin
      u = int'(a) + int'(b) + int'(cin);
      s = int'($signed(a)) + int'($signed(b)) + int'(cin);
      c = (u > 255);
    end else begin
      u = int'(a) - int'(b) - int'(cin);
      s = int'($signed(a)) - int'($signed(b)) - int'(cin);
      c = (u >= 0);
    end
    o = (s > 127) || (s < -128);
    return {o, c, u[7:0]};
  endfunction

  // Called #1 after a rising edge with instance k idle; returns #1 after the done edge (or timeout).
  task automatic run_op(input int k, input logic [7:0] a, b, input logic cin, sub,
                        output logic [9:0] res, output int lat, output int busyc,
                        output bit held_ok);
    a_r = a; b_r = b; cin_r = cin; sub_r = sub;
    start_r[k] = 1'b1;
    @(posedge clk); #1;
    start_r[k] = 1'b0;
    a_r = 8'($urandom); b_r = 8'($urandom); cin_r = 1'($urandom); sub_r = 1'($urandom);
    busyc   = int'(busy_w[k]);
    held_ok = (sum_w[k] === prev_sum[k]);
    lat     = 0;
    while (done_w[k] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done_w[k] !== 1'b1) begin
        busyc += int'(busy_w[k]);
        if (sum_w[k] !== prev_sum[k]) held_ok = 1'b0;
      end
    end
    res = {ovf_w[k], carry_w[k], sum_w[k]};
  endtask

  task automatic test_reset();
    reset = 1'b1; start_r = '0; a_r = '0; b_r = '0; cin_r = 1'b0; sub_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({busy_w[k], done_w[k], carry_w[k], ovf_w[k], sum_w[k]} !== 12'h000) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: got %h expected 000", k,
                 {busy_w[k], done_w[k], carry_w[k], ovf_w[k], sum_w[k]});
      end
      prev_sum[k] = 8'h00;
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic();
    logic [9:0] res; int lat, busyc; bit held;
    run_op(0, 8'h0F, 8'h01, 1'b0, 1'b0, res, lat, busyc, held);
    n_cmp++; if (res !== 10'h010) begin n_bad++; $display("FAIL add_basic_result: got %h expected 010", res); end
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL add_basic_latency: got %0d expected 8", lat); end
    n_cmp++; if (busyc !== 8) begin n_bad++; $display("FAIL add_basic_busy: got %0d expected 8", busyc); end
    n_cmp++; if (!held) begin n_bad++; $display("FAIL add_basic_hold: got changed expected held"); end
    prev_sum[0] = 8'h10;
    @(posedge clk); #1;
    n_cmp++; if (done_w[0] !== 1'b0) begin n_bad++; $display("FAIL add_basic_done_pulse: got %b expected 0", done_w[0]); end
  endtask

  task automatic test_wrap_b2b();
    logic [9:0] res; int lat, busyc; bit held;
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, res, lat, busyc, held);
    n_cmp++; if (res !== 10'h100) begin n_bad++; $display("FAIL wrap_result: got %h expected 100", res); end
    prev_sum[0] = 8'h00;
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, res, lat, busyc, held);
    n_cmp++; if (res !== 10'h280) begin n_bad++; $display("FAIL b2b_ovf_result: got %h expected 280", res); end
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
    n_cmp++; if (!held) begin n_bad++; $display("FAIL b2b_hold: got changed expected held"); end
    prev_sum[0] = 8'h80;
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    logic [9:0] res; int lat, busyc; bit held;
    run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, res, lat, busyc, held);
    n_cmp++; if (res !== 10'h0FE) begin n_bad++; $display("FAIL sub_borrow: got %h expected 0fe", res); end
    prev_sum[0] = 8'hFE;
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, res, lat, busyc, held);
    n_cmp++; if (res !== 10'h37F) begin n_bad++; $display("FAIL sub_ovf: got %h expected 37f", res); end
    prev_sum[0] = 8'h7F;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int lat, extra;
    a_r = 8'h10; b_r = 8'h22; cin_r = 1'b0; sub_r = 1'b0; start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_r = 8'h55; b_r = 8'h55; sub_r = 1'b1; start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    lat = 3;
    while (done_w[0] !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL ignore_latency: got %0d expected 8", lat); end
    n_cmp++;
    if ({ovf_w[0], carry_w[0], sum_w[0]} !== 10'h032) begin
      n_bad++; $display("FAIL ignore_result: got %h expected 032", {ovf_w[0], carry_w[0], sum_w[0]});
    end
    prev_sum[0] = 8'h32;
    extra = 0;
    repeat (12) begin @(posedge clk); #1; extra += int'(done_w[0]) + int'(busy_w[0]); end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL ignore_extra_done: got %0d expected 0", extra); end
  endtask

  task automatic test_reset_midrun();
    logic [9:0] res; int lat, busyc, extra; bit held;
    a_r = 8'h12; b_r = 8'h34; cin_r = 1'b0; sub_r = 1'b0; start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if ({busy_w[0], done_w[0], sum_w[0]} !== 10'h000) begin
      n_bad++; $display("FAIL midrun_reset: got %h expected 000", {busy_w[0], done_w[0], sum_w[0]});
    end
    for (int k = 0; k < 3; k++) prev_sum[k] = 8'h00;
    extra = 0;
    repeat (12) begin @(posedge clk); #1; extra += int'(done_w[0]); end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL midrun_no_done: got %0d expected 0", extra); end
    run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, res, lat, busyc, held);
    n_cmp++; if (res !== 10'h046) begin n_bad++; $display("FAIL midrun_recover: got %h expected 046", res); end
    prev_sum[0] = 8'h46;
    @(posedge clk); #1;
  endtask

  task automatic test_digit4();
    logic [9:0] res; int lat, busyc; bit held;
    run_op(1, 8'h99, 8'h67, 1'b1, 1'b0, res, lat, busyc, held);
    n_cmp++; if (res !== 10'h101) begin n_bad++; $display("FAIL d4_result: got %h expected 101", res); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL d4_latency: got %0d expected 2", lat); end
    n_cmp++; if (busyc !== 2) begin n_bad++; $display("FAIL d4_busy: got %0d expected 2", busyc); end
    prev_sum[1] = 8'h01;
    @(posedge clk); #1;
  endtask

  task automatic test_digit8();
    logic [9:0] res; int lat, busyc; bit held;
    run_op(2, 8'h80, 8'h80, 1'b0, 1'b0, res, lat, busyc, held);
    n_cmp++; if (res !== 10'h300) begin n_bad++; $display("FAIL d8_result: got %h expected 300", res); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL d8_latency: got %0d expected 1", lat); end
    prev_sum[2] = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [9:0] res, exp; int lat, busyc; bit held;
    logic [7:0] a, b; logic cin, sub;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        exp = model(a, b, cin, sub);
        run_op(k, a, b, cin, sub, res, lat, busyc, held);
        n_cmp++;
        if (res !== exp) begin
          n_bad++;
          $display("FAIL rand_result[d%0d] a=%h b=%h cin=%b sub=%b: got %h expected %h",
                   k, a, b, cin, sub, res, exp);
        end
        n_cmp++;
        if (lat !== steps_of(k) || busyc !== steps_of(k) || !held) begin
          n_bad++;
          $display("FAIL rand_timing[d%0d]: got lat=%0d busy=%0d held=%b expected %0d/%0d/1",
                   k, lat, busyc, held, steps_of(k), steps_of(k));
        end
        prev_sum[k] = exp[7:0];
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_wrap_b2b();
    test_sub();
    test_ignore_start();
    test_reset_midrun();
    test_digit4();
    test_digit8();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
